pipeline_mem_responder: RTL and testbench
=========================================

# pipeline_mem_responder

Data-memory responder on the pipeline's S3/S4 memory port: answers `addr_mem`/`write_mem`/`wdata_mem` from the memory-write stage and returns `rdata_mem` registered, so the register-write stage sees it one cycle later. Holds a 256×16 word RAM plus two memory-mapped I/O locations:
- an 8-bit LED output register;
- an 8-bit synchronized switch input.

Sits beside the pipeline assembly at top level, on the far end of its memory interface.

## Interface
Parameters:
- `RAM_WORDS`, 256, number of RAM words at addresses 0..RAM_WORDS-1 (must be ≤256).
- `LED_ADDR`, 9'h100, word address of the LED register (read/write).
- `SW_ADDR`, 9'h140, word address of the switch input (read-only).

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `addr_mem` input 9: word address from S3, sampled every cycle.
- `write_mem` input 1: store strobe from S3; write occurs on the rising edge while high.
- `wdata_mem` input 16: store data from S3.
- `rdata_mem` output 16: registered read data for S4.
- `sw_in` input 8: asynchronous board switches.
- `ledr` output 8: LED register contents.
- `bus_err` output 1: sticky flag, set by any access to an unmapped address.

## Operation
- Every cycle is an access; there is no read enable. Address decode, in priority order:
  1. RAM: `addr_mem < RAM_WORDS`.
  2. LED: `addr_mem == LED_ADDR`.
  3. SW: `addr_mem == SW_ADDR`.
  4. Otherwise the address is unmapped.
- RAM write: on an edge with `write_mem`=1, `ram[addr_mem[7:0]] <= wdata_mem`.
- RAM read, write-first semantics:
  - `rdata_mem <= write_mem ? wdata_mem : ram[addr]`.
  - A store therefore returns its own data.
  - A load in the cycle after a store to the same address returns the stored data.
- LED:
  - Write sets `ledr <= wdata_mem[7:0]`; `wdata_mem[15:8]` is ignored.
  - Read returns `{8'h00, ledr}`. A simultaneous write returns `{8'h00, wdata_mem[7:0]}`.
- SW:
  - `sw_in` passes through a two-flop synchronizer (`sw_meta` → `sw_sync`).
  - Read returns `{8'h00, sw_sync}`.
  - Writes are ignored; `rdata_mem` still returns `{8'h00, sw_sync}`.
- Unmapped:
  - Writes are dropped and no state changes except `bus_err`.
  - Reads return 16'h0000.
  - `bus_err <= 1` on that edge and holds until reset.
- Reset (`rst_n`=0, asynchronous):
  - `rdata_mem`=16'h0000, `ledr`=8'h00, `sw_meta`=`sw_sync`=8'h00, `bus_err`=0.
  - RAM contents are not reset and are preserved across reset.
  - While reset is asserted, `write_mem` is ignored: no RAM write and no LED update.
  - On the first edge after `rst_n` deasserts, normal operation resumes. There is no recovery delay.
- Addresses 9'h0FF and 9'h100 are distinct. The RAM index uses `addr_mem[7:0]` only after the range check, so there is no aliasing of LED/SW onto RAM.

## Timing
- Read latency is 1 cycle: address valid in cycle N → `rdata_mem` valid from the edge ending cycle N through cycle N+1, when S4 consumes it.
- Write takes effect on the edge ending cycle N. A read of the same RAM address in cycle N+1 sees the new data.
- `ledr` updates on the edge ending the write cycle and is visible in cycle N+1.
- Switch path:
  - A `sw_in` change before edge E is in `sw_sync` after edge E+1.
  - A read addressed in the cycle after E+1 returns it on `rdata_mem` after edge E+2.
- `bus_err` is set on the edge ending the offending cycle.
- Back-to-back accesses every cycle are required, with no stall or ready signal.

## Test plan
- RAM store/load: write 16'hBEEF to addr 9'h012 with `write_mem`=1 for one cycle. Next cycle, read 9'h012 → `rdata_mem`=16'hBEEF one edge later. Read 9'h013 → previous contents, unchanged.
- Write-first: in one cycle, write 16'h1234 to 9'h005 → `rdata_mem`=16'h1234 after that edge. Next cycle, write 16'h5678 to 9'h005 → 16'h5678.
- LED: write 16'hA55A to 9'h100 → `ledr`=8'h5A after the edge. Read 9'h100 → `rdata_mem`=16'h005A. RAM word 9'h000 is unchanged.
- Switches: set `sw_in`=8'hC3, hold, and read 9'h140 every cycle → `rdata_mem` = 16'h0000 for the first 2 reads after the change, then 16'h00C3. Write 16'hFFFF to 9'h140 → no change to any state.
- Unmapped/error: write 16'hFFFF to 9'h1FF → `bus_err`=1 after the edge, `rdata_mem`=16'h0000, `ledr` and RAM unchanged. `bus_err` stays 1 across 10 legal accesses.
- Reset mid-operation: with 16'h0042 stored at 9'h020 and `ledr`=8'hFF, assert `rst_n`=0 asynchronously mid-cycle while `write_mem`=1 to 9'h020 with 16'h9999.
  - Immediately: `rdata_mem`=0, `ledr`=0, `bus_err`=0.
  - After release, a read of 9'h020 → 16'h0042.

Source files
------------

// File: rtl/pipeline_mem_responder.sv
// Data-memory responder on the pipeline S3/S4 port: 256x16 RAM plus LED and
// switch I/O words, with registered write-first read data and a sticky bus error.
module pipeline_mem_responder #(
    parameter int unsigned RAM_WORDS = 256,
    parameter logic [8:0]  LED_ADDR  = 9'h100,
    parameter logic [8:0]  SW_ADDR   = 9'h140
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  addr_mem,
    input  logic        write_mem,
    input  logic [15:0] wdata_mem,
    output logic [15:0] rdata_mem,
    input  logic [7:0]  sw_in,
    output logic [7:0]  ledr,
    output logic        bus_err
);

    logic [15:0] ram [RAM_WORDS];

    logic        sel_ram;
    logic        sel_led;
    logic        sel_sw;
    logic        sel_none;
    logic [7:0]  ram_idx;
    logic [7:0]  sw_meta;
    logic [7:0]  sw_sync;
    logic [15:0] rdata_next;

    // Range check comes first, so LED/SW never alias onto RAM through addr_mem[7:0].
    assign sel_ram  = ({1'b0, addr_mem} < 10'(RAM_WORDS));
    assign sel_led  = !sel_ram && (addr_mem == LED_ADDR);
    assign sel_sw   = !sel_ram && !sel_led && (addr_mem == SW_ADDR);
    assign sel_none = !(sel_ram || sel_led || sel_sw);
    assign ram_idx  = addr_mem[7:0];

    always_comb begin
        rdata_next = 16'h0000;
        if (sel_ram) begin
            rdata_next = write_mem ? wdata_mem : ram[ram_idx];
        end else if (sel_led) begin
            rdata_next = {8'h00, (write_mem ? wdata_mem[7:0] : ledr)};
        end else if (sel_sw) begin
            rdata_next = {8'h00, sw_sync};
        end
    end

    // RAM has no reset but shares this block so that writes are blocked while
    // rst_n is low; its contents survive reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_mem <= 16'h0000;
            ledr      <= 8'h00;
            sw_meta   <= 8'h00;
            sw_sync   <= 8'h00;
            bus_err   <= 1'b0;
        end else begin
            rdata_mem <= rdata_next;
            sw_meta   <= sw_in;
            sw_sync   <= sw_meta;
            if (write_mem && sel_ram) begin
                ram[ram_idx] <= wdata_mem;
            end
            if (write_mem && sel_led) begin
                ledr <= wdata_mem[7:0];
            end
            if (sel_none) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_mem_responder.sv
// Scoreboard bench for pipeline_mem_responder: each access pushes its expected
// read data, each test pops after the edge and compares inline.
module tb_pipeline_mem_responder;

    logic        clk;
    logic        rst_n;
    logic [8:0]  addr_mem;
    logic        write_mem;
    logic [15:0] wdata_mem;
    logic [15:0] rdata_mem;
    logic [7:0]  sw_in;
    logic [7:0]  ledr;
    logic        bus_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] sb [$];

    logic [15:0] m_ram [256];
    logic [7:0]  m_led;
    logic        m_err;
    logic [7:0]  m_meta;
    logic [7:0]  m_sync;

    pipeline_mem_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr_mem  (addr_mem),
        .write_mem (write_mem),
        .wdata_mem (wdata_mem),
        .rdata_mem (rdata_mem),
        .sw_in     (sw_in),
        .ledr      (ledr),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one access for one cycle, pushing the expected read data and
    // advancing the reference model across the edge. Returns at edge + 1.
    task automatic drive(input logic [8:0] a, input logic we, input logic [15:0] wd);
        logic [15:0] e;
        addr_mem  = a;
        write_mem = we;
        wdata_mem = wd;
        if (a < 9'h100)       e = we ? wd : m_ram[a[7:0]];
        else if (a == 9'h100) e = {8'h00, (we ? wd[7:0] : m_led)};
        else if (a == 9'h140) e = {8'h00, m_sync};
        else                  e = 16'h0000;
        sb.push_back(e);
        if (we && a < 9'h100)  m_ram[a[7:0]] = wd;
        if (we && a == 9'h100) m_led = wd[7:0];
        if (!(a < 9'h100 || a == 9'h100 || a == 9'h140)) m_err = 1'b1;
        m_sync = m_meta;
        m_meta = sw_in;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pop_exp();
        logic [15:0] e;
        e = 16'hxxxx;
        if (sb.size() > 0) e = sb.pop_front();
        return e;
    endfunction

    task automatic test_reset();
        logic [15:0] e;
        rst_n     = 1'b0;
        sw_in     = 8'h00;
        addr_mem  = 9'h100;
        write_mem = 1'b1;
        wdata_mem = 16'h00FF;
        m_led = 8'h00; m_err = 1'b0; m_meta = 8'h00; m_sync = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (rdata_mem !== 16'h0000) begin n_err++; $display("FAIL reset_rdata got=%h exp=0000", rdata_mem); end
        n_cmp++; if (ledr !== 8'h00) begin n_err++; $display("FAIL reset_ledr got=%h exp=00", ledr); end
        n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL reset_bus_err got=%b exp=0", bus_err); end
        write_mem = 1'b0;
        addr_mem  = 9'h000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // First edge after release was a plain read; the write during reset must not have landed.
        n_cmp++; if (ledr !== 8'h00) begin n_err++; $display("FAIL reset_write_ignored ledr got=%h exp=00", ledr); end
        e = pop_exp();
    endtask

    task automatic test_ram_store_load();
        logic [15:0] e;
        drive(9'h013, 1'b1, 16'h3131);
        e = pop_exp();
        drive(9'h012, 1'b1, 16'hBEEF);
        e = pop_exp();
        n_cmp++; if (rdata_mem !== e) begin n_err++; $display("FAIL ram_store_echo got=%h exp=%h", rdata_mem, e); end
        drive(9'h012, 1'b0, 16'h0000);
        e = pop_exp();
        n_cmp++; if (rdata_mem !== 16'hBEEF) begin n_err++; $display("FAIL ram_load got=%h exp=BEEF", rdata_mem); end
        drive(9'h013, 1'b0, 16'h0000);
        e = pop_exp();
        n_cmp++; if (rdata_mem !== e) begin n_err++; $display("FAIL ram_neighbor got=%h exp=%h", rdata_mem, e); end
    endtask

    task automatic test_write_first();
        logic [15:0] e;
        drive(9'h005, 1'b1, 16'h1234);
        e = pop_exp();
        n_cmp++; if (rdata_mem !== 16'h1234) begin n_err++; $display("FAIL write_first_a got=%h exp=1234", rdata_mem); end
        drive(9'h005, 1'b1, 16'h5678);
        e = pop_exp();
        n_cmp++; if (rdata_mem !== 16'h5678) begin n_err++; $display("FAIL write_first_b got=%h exp=5678", rdata_mem); end
        drive(9'h005, 1'b0, 16'h0000);
        e = pop_exp();
        n_cmp++; if (rdata_mem !== e) begin n_err++; $display("FAIL write_first_load got=%h exp=%h", rdata_mem, e); end
    endtask

    task automatic test_led();
        logic [15:0] e;
        drive(9'h000, 1'b1, 16'h0A0A);
        e = pop_exp();
        drive(9'h0FF, 1'b1, 16'h7777);
        e = pop_exp();
        drive(9'h100, 1'b1, 16'hA55A);
        e = pop_exp();
        n_cmp++; if (ledr !== 8'h5A) begin n_err++; $display("FAIL led_write ledr got=%h exp=5A", ledr); end
        n_cmp++; if (rdata_mem !== 16'h005A) begin n_err++; $display("FAIL led_write_echo got=%h exp=005A", rdata_mem); end
        drive(9'h100, 1'b0, 16'h0000);
        e = pop_exp();
        n_cmp++; if (rdata_mem !== e) begin n_err++; $display("FAIL led_read got=%h exp=%h", rdata_mem, e); end
        drive(9'h000, 1'b0, 16'h0000);
        e = pop_exp();
        n_cmp++; if (rdata_mem !== 16'h0A0A) begin n_err++; $display("FAIL led_no_ram_alias got=%h exp=0A0A", rdata_mem); end
        drive(9'h0FF, 1'b0, 16'h0000);
        e = pop_exp();
        n_cmp++; if (rdata_mem !== e) begin n_err++; $display("FAIL ram_0ff got=%h exp=%h", rdata_mem, e); end
    endtask

    task automatic test_switches();
        logic [15:0] e;
        logic [15:0] want [4];
        want[0] = 16'h0000; want[1] = 16'h0000; want[2] = 16'h00C3; want[3] = 16'h00C3;
        sw_in = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            drive(9'h140, 1'b0, 16'h0000);
            e = pop_exp();
            n_cmp++;
            if (rdata_mem !== want[i]) begin
                n_err++; $display("FAIL sw_sync_read%0d got=%h exp=%h", i, rdata_mem, want[i]);
            end
        end
        drive(9'h140, 1'b1, 16'hFFFF);
        e = pop_exp();
        n_cmp++; if (rdata_mem !== e) begin n_err++; $display("FAIL sw_write_ignored rdata got=%h exp=%h", rdata_mem, e); end
        n_cmp++; if (ledr !== m_led) begin n_err++; $display("FAIL sw_write_ledr got=%h exp=%h", ledr, m_led); end
        n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL sw_write_bus_err got=%b exp=0", bus_err); end
    endtask

    task automatic test_unmapped();
        logic [15:0] e;
        drive(9'h1FF, 1'b1, 16'hFFFF);
        e = pop_exp();
        n_cmp++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL unmapped_bus_err got=%b exp=1", bus_err); end
        n_cmp++; if (rdata_mem !== 16'h0000) begin n_err++; $display("FAIL unmapped_rdata got=%h exp=0000", rdata_mem); end
        n_cmp++; if (ledr !== m_led) begin n_err++; $display("FAIL unmapped_ledr got=%h exp=%h", ledr, m_led); end
        drive(9'h012, 1'b0, 16'h0000);
        e = pop_exp();
        n_cmp++; if (rdata_mem !== e) begin n_err++; $display("FAIL unmapped_ram_kept got=%h exp=%h", rdata_mem, e); end
        for (int i = 0; i < 10; i++) begin
            drive(((i % 2) == 0) ? 9'h005 : 9'h100, 1'b0, 16'h0000);
            e = pop_exp();
            n_cmp++;
            if (bus_err !== 1'b1 || rdata_mem !== e) begin
                n_err++; $display("FAIL sticky_err%0d bus_err=%b rdata got=%h exp=%h", i, bus_err, rdata_mem, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        logic [15:0] v;
        for (int i = 0; i < 16; i++) begin
            v = 16'($urandom);
            drive(9'h030 + 9'(i), 1'b1, v);
            e = pop_exp();
            n_cmp++; if (rdata_mem !== v) begin n_err++; $display("FAIL b2b_store%0d got=%h exp=%h", i, rdata_mem, v); end
        end
        for (int i = 0; i < 16; i++) begin
            drive(9'h030 + 9'(15 - i), 1'b0, 16'h0000);
            e = pop_exp();
            n_cmp++; if (rdata_mem !== e) begin n_err++; $display("FAIL b2b_load%0d got=%h exp=%h", i, rdata_mem, e); end
        end
        for (int i = 0; i < 8; i++) begin
            v = 16'($urandom);
            drive(9'h050, 1'b1, v);
            e = pop_exp();
            drive(9'h050, 1'b0, 16'h0000);
            e = pop_exp();
            n_cmp++; if (rdata_mem !== v) begin n_err++; $display("FAIL store_then_load%0d got=%h exp=%h", i, rdata_mem, v); end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] e;
        drive(9'h020, 1'b1, 16'h0042);
        e = pop_exp();
        drive(9'h100, 1'b1, 16'h00FF);
        e = pop_exp();
        n_cmp++; if (ledr !== 8'hFF) begin n_err++; $display("FAIL pre_reset_ledr got=%h exp=FF", ledr); end
        addr_mem  = 9'h020;
        write_mem = 1'b1;
        wdata_mem = 16'h9999;
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rdata_mem !== 16'h0000) begin n_err++; $display("FAIL async_reset_rdata got=%h exp=0000", rdata_mem); end
        n_cmp++; if (ledr !== 8'h00) begin n_err++; $display("FAIL async_reset_ledr got=%h exp=00", ledr); end
        n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL async_reset_bus_err got=%b exp=0", bus_err); end
        m_led = 8'h00; m_err = 1'b0; m_meta = 8'h00; m_sync = 8'h00;
        @(posedge clk);
        #2;
        write_mem = 1'b0;
        rst_n = 1'b1;
        drive(9'h020, 1'b0, 16'h0000);
        e = pop_exp();
        n_cmp++; if (rdata_mem !== 16'h0042) begin n_err++; $display("FAIL reset_ram_kept got=%h exp=0042", rdata_mem); end
        n_cmp++; if (rdata_mem !== e) begin n_err++; $display("FAIL reset_ram_model got=%h exp=%h", rdata_mem, e); end
    endtask

    initial begin
        addr_mem  = 9'h000;
        write_mem = 1'b0;
        wdata_mem = 16'h0000;
        sw_in     = 8'h00;
        rst_n     = 1'b0;
        test_reset();
        test_ram_store_load();
        test_write_first();
        test_led();
        test_switches();
        test_back_to_back();
        test_unmapped();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
